// File: rtl/sand_reduce.sv
// rtl/sand_reduce.sv - framed AND/OR/XOR/NAND bit reduction with output hold handshake
// Optional SAND_POPCNT_EN adds out_pop, the ones count of each frame.
module sand_reduce #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SAND_POPCNT_EN
  ,
  output logic [$clog2(WIDTH*BEATS+1)-1:0] out_pop
`endif
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  localparam logic [1:0] M_AND  = 2'b00;
  localparam logic [1:0] M_OR   = 2'b01;
  localparam logic [1:0] M_XOR  = 2'b10;
  localparam logic [1:0] M_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;

  logic            r_acc;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_frame_mode;
  logic            r_out;
  logic            r_out_valid;

  logic [1:0]      w_mode_eff;
  logic            w_beat_red;
  logic            w_acc_next;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_frame_end;
  logic            w_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = (r_state != S_HOLD);
    w_accept     = in_valid & (r_state != S_HOLD);
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_state_next = w_frame_end ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The first beat of a frame takes its mode straight from the input.
  always_comb begin
    w_mode_eff = (r_state == S_IDLE) ? mode : r_frame_mode;
    case (w_mode_eff)
      M_OR:    w_beat_red = |in_data;
      M_XOR:   w_beat_red = ^in_data;
      default: w_beat_red = &in_data;
    endcase
    if (r_state == S_IDLE) begin
      w_acc_next = w_beat_red;
    end else begin
      case (w_mode_eff)
        M_OR:    w_acc_next = r_acc | w_beat_red;
        M_XOR:   w_acc_next = r_acc ^ w_beat_red;
        default: w_acc_next = r_acc & w_beat_red;
      endcase
    end
    w_cnt_inc   = r_cnt + 1'b1;
    w_frame_end = in_last | (w_cnt_inc == BEATS_C);
    w_result    = (w_mode_eff == M_NAND) ? ~w_acc_next : w_acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_frame_mode <= M_AND;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      if (r_state == S_IDLE) begin
        r_frame_mode <= mode;
      end
      if (w_frame_end) begin
        r_cnt       <= '0;
        r_out       <= w_result;
        r_out_valid <= 1'b1;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end else if ((r_state == S_HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef SAND_POPCNT_EN
  localparam int PW = $clog2(WIDTH * BEATS + 1);

  logic [PW-1:0] r_pop_acc;
  logic [PW-1:0] r_out_pop;
  logic [PW-1:0] w_beat_pop;
  logic [PW-1:0] w_pop_next;

  always_comb begin
    w_beat_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_beat_pop = w_beat_pop + PW'(in_data[i]);
    end
    w_pop_next = ((r_state == S_IDLE) ? '0 : r_pop_acc) + w_beat_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_acc <= '0;
      r_out_pop <= '0;
    end else if (w_accept) begin
      r_pop_acc <= w_pop_next;
      if (w_frame_end) begin
        r_out_pop <= w_pop_next;
      end
    end
  end

  assign out_pop = r_out_pop;
`endif

endmodule

// File: doc/sand_reduce.md
SAND_REDUCE -- requirements
Module: sand_reduce

Interface
REQ-001 Parameter WIDTH, default 8: bits per input word (>=1).
REQ-002 Parameter BEATS, default 4: maximum words per frame (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_data  input  WIDTH  operand word.
REQ-006 in_valid  input  1  in_data/in_last/mode valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_last  input  1  accepted word closes frame early.
REQ-009 mode  input  2  reduction: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 out  output  1  frame reduction result (registered).
REQ-011 out_valid  output  1  out holds a completed frame result.
REQ-012 out_ready  input  1  consumer takes result this cycle.

Function
REQ-013 Accept = in_valid & in_ready; no other input affects state except rst.
REQ-014 FSM states IDLE, ACCUM, HOLD; in_ready = 1 in IDLE/ACCUM, 0 in HOLD.
REQ-015 IDLE: on accept, latch mode into frame_mode, acc = reduce(in_data), beat count = 1; go ACCUM, or HOLD if frame ends on this beat.
REQ-016 ACCUM: on accept, acc = op(acc, reduce(in_data)) and beat count +1; mode input ignored until next frame.
REQ-017 reduce/op per frame_mode: AND and NAND use bitwise AND over all bits of all beats; OR uses OR; XOR uses parity across all WIDTH*BEATS accepted bits.
REQ-018 Frame ends on the accept where in_last = 1 or beat count reaches BEATS; BEATS = 1 makes every accept a frame.
REQ-019 On frame end: out <= acc result (inverted for NAND), out_valid <= 1 the cycle after the final accept; state HOLD.
REQ-020 HOLD: out and out_valid stable while out_ready = 0; in_valid ignored.
REQ-021 HOLD with out_ready = 1: out_valid <= 0, state IDLE next cycle; out keeps last value; new frame accepted no earlier than the following cycle (one bubble).
REQ-022 in_valid = 0 in ACCUM: no change; a frame may stall indefinitely.
REQ-023 Beat counter width $clog2(BEATS+1); never exceeds BEATS; cleared on frame end.

Reset
REQ-024 rst = 1 at a rising edge: state IDLE, out = 0, out_valid = 0, acc = 0, beat count = 0, frame_mode = 00; partial frame discarded.
REQ-025 During rst = 1 cycle, no word is accepted regardless of in_valid; in_ready = 1 from first cycle after rst deasserts.
REQ-026 rst wins over any simultaneous accept or output handshake.

Configuration
REQ-027 Macro SAND_POPCNT_EN defined: adds output out_pop, width $clog2(WIDTH*BEATS+1), equal to the count of 1 bits across all accepted words of the frame, updated and held with out, reset to 0.
REQ-028 Macro SAND_POPCNT_EN undefined: out_pop port and its counter are absent; all other behaviour identical.

Verification (WIDTH=8, BEATS=4)
REQ-029 mode=00, accept FF,FF,FF,FF back-to-back -> out_valid=1 and out=1 one cycle after 4th accept; in_ready=0 until out_ready.
REQ-030 mode=00, accept FF,FF,FE,FF -> out=0; same frame with mode=11 -> out=1; mode toggled mid-frame has no effect.
REQ-031 mode=10, accept 01 then 03 with in_last=1 -> frame ends after 2 beats, out=1; next frame counts from beat 1.
REQ-032 Completed frame, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out/out_valid stable; out_ready=1 -> out_valid=0 next cycle, next word accepted the cycle after.
REQ-033 rst pulsed after 2 accepted beats -> out_valid=0, out=0; following 4-beat frame of FF completes only after 4 new accepts with out=1.
REQ-034 SAND_POPCNT_EN defined, mode=01, accept FF,0F,00,01 -> out=1, out_pop=13.
